// File: rtl/rsa_result_capture_if.sv
// Handshake bundle between the encrypt/decrypt modExp pair and the result-capture stage.
interface rsa_result_capture_if #(
   parameter int unsigned MSG_W = 12
);
   logic [MSG_W-1:0] msg_plain;
   logic             plain_valid;
   logic [MSG_W-1:0] msg_enc;
   logic             enc_done;
   logic [MSG_W-1:0] msg_dec;
   logic             dec_done;

   modport master (
      output msg_plain, plain_valid, msg_enc, enc_done, msg_dec, dec_done
   );

   modport slave (
      input  msg_plain, plain_valid, msg_enc, enc_done, msg_dec, dec_done
   );
endinterface

// File: rtl/rsa_result_capture.sv
// Captures plaintext/ciphertext/decrypted results, checks the round trip, drives board LEDs.
// Optional `LATENCY_CNT_EN: per-transaction cycle counter shown while both buttons are held.
module rsa_result_capture #(
   parameter int unsigned MSG_W           = 12,
   parameter int unsigned DEBOUNCE_CYCLES = 16,
   parameter int unsigned TIMEOUT_CYCLES  = 1000000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   rsa_result_capture_if.slave  rsa,
   input  logic                 btn_enc,
   input  logic                 btn_dec,
   output logic [15:0]          led
);

   localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);
   localparam int unsigned DbW    = $clog2(DEBOUNCE_CYCLES + 1);
   // Last timer value seen in a wait state before the timer would reach TIMEOUT_CYCLES-1.
   localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 2);
   localparam logic [DbW-1:0]    DbLast    = DbW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StWaitEnc, StWaitDec, StDone, StTimeout} state_e;
   typedef enum logic [1:0] {ViewPlain, ViewEnc, ViewDec} view_e;

   state_e            state_q;
   view_e             view_q;
   logic [MSG_W-1:0]  plain_q, enc_q, dec_q;
   logic              match_q, mismatch_q, timeout_q;
   logic [TimerW-1:0] timer_q;
`ifdef LATENCY_CNT_EN
   logic [TimerW-1:0] lat_q;
`endif

   // Button conditioning: index 0 = btn_enc, index 1 = btn_dec.
   logic [1:0]     btn_raw, sync1_q, sync2_q, db_q, db_flip, db_rise;
   logic [DbW-1:0] db_cnt_q [2];

   assign btn_raw = {btn_dec, btn_enc};

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         db_flip[i] = (sync2_q[i] != db_q[i]) && (db_cnt_q[i] == DbLast);
      end
      db_rise = db_flip & sync2_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         db_q    <= '0;
         for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         for (int i = 0; i < 2; i++) begin
            if (sync2_q[i] == db_q[i]) begin
               db_cnt_q[i] <= '0;
            end else if (db_flip[i]) begin
               db_cnt_q[i] <= '0;
               db_q[i]     <= sync2_q[i];
            end else begin
               db_cnt_q[i] <= db_cnt_q[i] + DbW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         view_q <= ViewPlain;
      end else if (db_rise[1]) begin
         view_q <= ViewDec;
      end else if (db_rise[0]) begin
         view_q <= ViewEnc;
      end
   end

   // Transaction FSM; a new plain_valid always wins and restarts from scratch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         plain_q    <= '0;
         enc_q      <= '0;
         dec_q      <= '0;
         match_q    <= 1'b0;
         mismatch_q <= 1'b0;
         timeout_q  <= 1'b0;
         timer_q    <= '0;
`ifdef LATENCY_CNT_EN
         lat_q      <= '0;
`endif
      end else if (rsa.plain_valid) begin
         state_q    <= StWaitEnc;
         plain_q    <= rsa.msg_plain;
         enc_q      <= '0;
         dec_q      <= '0;
         match_q    <= 1'b0;
         mismatch_q <= 1'b0;
         timeout_q  <= 1'b0;
         timer_q    <= '0;
`ifdef LATENCY_CNT_EN
         lat_q      <= '0;
`endif
      end else begin
         case (state_q)
            StWaitEnc, StWaitDec: begin
               timer_q <= timer_q + TimerW'(1);
`ifdef LATENCY_CNT_EN
               lat_q   <= lat_q + TimerW'(1);
`endif
               if (state_q == StWaitEnc && rsa.enc_done) begin
                  enc_q   <= rsa.msg_enc;
                  state_q <= StWaitDec;
               end else if (state_q == StWaitDec && rsa.dec_done) begin
                  dec_q      <= rsa.msg_dec;
                  match_q    <= (rsa.msg_dec == plain_q);
                  mismatch_q <= (rsa.msg_dec != plain_q);
                  state_q    <= StDone;
               end else if (timer_q == TimerLast) begin
                  timeout_q <= 1'b1;
                  state_q   <= StTimeout;
               end
            end
            default: ;
         endcase
      end
   end

   logic [MSG_W-1:0] sel_cap;
   logic [11:0]      view12;
   logic             busy;
   logic [15:0]      led_d;

   assign busy = (state_q == StWaitEnc) || (state_q == StWaitDec);

   always_comb begin
      case (view_q)
         ViewEnc: sel_cap = enc_q;
         ViewDec: sel_cap = dec_q;
         default: sel_cap = plain_q;
      endcase
      view12 = 12'(sel_cap);
`ifdef LATENCY_CNT_EN
      if (db_q == 2'b11) begin
         view12 = (32'(lat_q) > 32'd4095) ? 12'hFFF : 12'(lat_q);
      end
`endif
      led_d = {timeout_q, busy, mismatch_q, match_q, view12};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led <= '0;
      end else begin
         led <= led_d;
      end
   end

endmodule

// File: tb/tb_rsa_result_capture.sv
// Scoreboard bench for rsa_result_capture: transaction-level model, cycle-tagged expectations.
module tb_rsa_result_capture;

   localparam int unsigned MSG_W = 12;
   localparam int unsigned DB    = 16;
   localparam int unsigned TC    = 100;

   logic        clk;
   logic        rst_n;
   logic        btn_enc, btn_dec;
   logic [15:0] led;

   rsa_result_capture_if #(.MSG_W(MSG_W)) rsa ();

   rsa_result_capture #(
      .MSG_W          (MSG_W),
      .DEBOUNCE_CYCLES(DB),
      .TIMEOUT_CYCLES (TC)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .rsa    (rsa),
      .btn_enc(btn_enc),
      .btn_dec(btn_dec),
      .led    (led)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int unsigned cyc;
      logic [15:0] mask;
      logic [15:0] val;
      string       name;
   } exp_t;

   exp_t        sb_q[$];
   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   bit          end_req  = 1'b0;
   bit          mon_done = 1'b0;

   // Monitor: compares led against every expectation whose cycle has come.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e = sb_q.pop_front();
            n_checks++;
            if ((led & e.mask) !== (e.val & e.mask)) begin
               n_fail++;
               $display("FAIL %s at cycle %0d: led=%h, required %h (mask %h)",
                        e.name, cyc, led, e.val, e.mask);
            end
         end
         if (end_req && !mon_done) begin
            while (sb_q.size() > 0) begin
               e = sb_q.pop_front();
               n_checks++;
               n_fail++;
               $display("FAIL %s: expectation for cycle %0d never checked", e.name, e.cyc);
            end
            mon_done = 1'b1;
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit expired");
      $fatal(1);
   end

   // Transaction-level reference model. State: 0 idle, 1 wait enc, 2 wait dec, 3 done, 4 timeout.
   logic [11:0] m_plain, m_enc, m_dec;
   int          m_st, m_view;
   bit          m_match, m_mis, m_to;

   function automatic logic [15:0] model_led();
      logic [11:0] v;
      v = (m_view == 2) ? m_dec : (m_view == 1) ? m_enc : m_plain;
      return {m_to, (m_st == 1 || m_st == 2), m_mis, m_match, v};
   endfunction

   task automatic model_reset();
      m_plain = '0; m_enc = '0; m_dec = '0;
      m_st = 0; m_view = 0;
      m_match = 0; m_mis = 0; m_to = 0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_led(input int unsigned dly, input logic [15:0] mask,
                             input logic [15:0] val, input string name);
      exp_t e;
      e.cyc = cyc + dly; e.mask = mask; e.val = val; e.name = name;
      sb_q.push_back(e);
   endtask

   task automatic pulse(input bit pv, input logic [11:0] pm, input bit ev, input logic [11:0] em,
                        input bit dv, input logic [11:0] dm, input string name);
      rsa.plain_valid = pv; rsa.msg_plain = pm;
      rsa.enc_done    = ev; rsa.msg_enc   = em;
      rsa.dec_done    = dv; rsa.msg_dec   = dm;
      step(1);
      rsa.plain_valid = 1'b0; rsa.enc_done = 1'b0; rsa.dec_done = 1'b0;
      if (pv) begin
         m_plain = pm; m_enc = '0; m_dec = '0;
         m_match = 0; m_mis = 0; m_to = 0; m_st = 1;
      end else if (m_st == 1 && ev) begin
         m_enc = em; m_st = 2;
      end else if (m_st == 2 && dv) begin
         m_dec = dm; m_match = (dm == m_plain); m_mis = (dm != m_plain); m_st = 3;
      end
      expect_led(1, 16'hFFFF, model_led(), name);
   endtask

   task automatic press(input bit pe, input bit pd, input int hold, input string name);
      btn_enc = pe; btn_dec = pd;
      step(hold);
      if (hold >= int'(DB) + 2) begin
         if (pd) m_view = 2;
         else if (pe) m_view = 1;
      end
      expect_led(1, 16'hFFFF, model_led(), name);
      btn_enc = 1'b0; btn_dec = 1'b0;
      step(int'(DB) + 8);
      expect_led(1, 16'hFFFF, model_led(), {name, "_rel"});
   endtask

   initial begin
      logic [11:0] p, e, d;
      int          n1, n2, vsel;

      rst_n = 1'b0; btn_enc = 1'b0; btn_dec = 1'b0;
      rsa.plain_valid = 1'b0; rsa.enc_done = 1'b0; rsa.dec_done = 1'b0;
      rsa.msg_plain = '0; rsa.msg_enc = '0; rsa.msg_dec = '0;
      model_reset();
      expect_led(0, 16'hFFFF, 16'h0000, "reset");
      step(3);
      rst_n = 1'b1;
      step(2);
      expect_led(1, 16'hFFFF, 16'h0000, "post_reset");

      // Matching round trip, PLAIN view.
      pulse(1, 12'h0A5, 0, 0, 0, 0, "t1_plain");
      step(39);
      expect_led(1, 16'h4000, 16'h4000, "t1_busy");
      pulse(0, 0, 1, 12'h3C1, 0, 0, "t1_enc");
      step(39);
      pulse(0, 0, 0, 0, 1, 12'h0A5, "t1_dec");
      step(2);

      // Mismatch, then button-selected views and bounce rejection.
      pulse(1, 12'h0A5, 0, 0, 0, 0, "t2_plain");
      step(39);
      pulse(0, 0, 1, 12'h3C1, 0, 0, "t2_enc");
      step(39);
      pulse(0, 0, 0, 0, 1, 12'h0A4, "t2_dec");
      press(0, 1, 25, "t2_btn_dec");
      for (int i = 0; i < 4; i++) begin
         btn_enc = 1'b1; step(5);
         btn_enc = 1'b0; step(5);
      end
      step(25);
      expect_led(1, 16'hFFFF, model_led(), "t2_bounce");
      press(1, 0, 25, "t2_btn_enc");

      // Timeout after TC cycles with no enc_done.
      pulse(1, 12'h123, 0, 0, 0, 0, "t3_plain");
      step(97);
      expect_led(1, 16'hFFFF, model_led(), "t3_before_timeout");
      step(2);
      m_st = 4; m_to = 1;
      expect_led(1, 16'hFFFF, model_led(), "t3_timeout");
      step(5);
      pulse(0, 0, 1, 12'h555, 0, 0, "t3_late_enc");
      pulse(1, 12'h321, 0, 0, 0, 0, "t3_restart");

      // Restart beats a same-cycle enc_done; state stays WAIT_ENC.
      step(5);
      pulse(1, 12'h456, 1, 12'h7E7, 0, 0, "t4_restart_enc");
      pulse(0, 0, 1, 12'h111, 0, 0, "t4_enc");
      pulse(0, 0, 0, 0, 1, 12'h456, "t4_dec");

      // dec_done ignored in WAIT_ENC and in DONE; restart drops a same-cycle dec_done.
      pulse(1, 12'h0F0, 0, 0, 0, 0, "t5_plain");
      pulse(0, 0, 1, 12'h0AB, 1, 12'h0F0, "t5_enc_dec");
      pulse(1, 12'h0F1, 0, 0, 1, 12'h0F1, "t5_restart_dec");
      pulse(0, 0, 1, 12'h222, 0, 0, "t5_enc");
      pulse(0, 0, 0, 0, 1, 12'h0F1, "t5_dec");
      pulse(0, 0, 0, 0, 1, 12'h999, "t5_stray_dec");

      // Randomized transactions with random views and stray pulses.
      for (int t = 0; t < 10; t++) begin
         vsel = $urandom_range(0, 2);
         if (vsel == 1) press(1, 0, 25, "rnd_view_enc");
         else if (vsel == 2) press(0, 1, 25, "rnd_view_dec");
         p  = 12'($urandom);
         e  = 12'($urandom);
         d  = ($urandom_range(0, 1) == 1) ? p : 12'($urandom);
         n1 = $urandom_range(0, 35);
         n2 = $urandom_range(0, 35);
         pulse(1, p, 0, 0, 0, 0, "rnd_plain");
         step(n1);
         if ($urandom_range(0, 2) == 0) pulse(0, 0, 0, 0, 1, 12'($urandom), "rnd_stray_dec");
         pulse(0, 0, 1, e, 0, 0, "rnd_enc");
         step(n2);
         pulse(0, 0, 0, 0, 1, d, "rnd_dec");
         step(2);
      end

      // Reset in WAIT_DEC clears led at once and drops pending pulses.
      pulse(1, 12'h0C3, 0, 0, 0, 0, "t7_plain");
      step(3);
      pulse(0, 0, 1, 12'h0D4, 0, 0, "t7_enc");
      step(5);
      rst_n = 1'b0;
      model_reset();
      expect_led(0, 16'hFFFF, 16'h0000, "t7_reset_now");
      step(3);
      rst_n = 1'b1;
      step(3);
      expect_led(1, 16'hFFFF, 16'h0000, "t7_after_reset");
      pulse(0, 0, 0, 0, 1, 12'h0C3, "t7_stale_dec");

      // dec_done 75 cycles after plain_valid, then both buttons held.
      pulse(1, 12'h0A5, 0, 0, 0, 0, "t8_plain");
      step(29);
      pulse(0, 0, 1, 12'h3C1, 0, 0, "t8_enc");
      step(44);
      pulse(0, 0, 0, 0, 1, 12'h0A5, "t8_dec");
      btn_enc = 1'b1; btn_dec = 1'b1;
      step(25);
      m_view = 2;
`ifdef LATENCY_CNT_EN
      expect_led(1, 16'hFFFF, {model_led() & 16'hF000} | 16'd75, "t8_latency");
`else
      expect_led(1, 16'hFFFF, model_led(), "t8_both_dec");
`endif
      btn_enc = 1'b0; btn_dec = 1'b0;
      step(int'(DB) + 8);
      expect_led(1, 16'hFFFF, model_led(), "t8_release");

      step(4);
      end_req = 1'b1;
      for (int i = 0; i < 10 && !mon_done; i++) step(1);
      if (!mon_done) begin
         $display("FAIL monitor: scoreboard did not drain");
         $fatal(1);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
